// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if
//   Bundles the FIFO read port, the flush request, the packed output stream
//   and the underrun counter of fifo_word_packer.
//   master : the packer side (drives read request, output word, counter)
//   slave  : the surrounding FIFO / downstream side
interface fifo_word_packer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4
);
   logic                          fifo_rd_enb;
   logic [DATA_WIDTH-1:0]         fifo_rd_data;
   logic                          fifo_empty;
   logic                          fifo_underrun;
   logic                          flush;
   logic [DATA_WIDTH*LANES-1:0]   m_data;
   logic [LANES-1:0]              m_keep;
   logic                          m_valid;
   logic                          m_ready;
   logic [7:0]                    underrun_cnt;

   modport master (
      output fifo_rd_enb,
      input  fifo_rd_data,
      input  fifo_empty,
      input  fifo_underrun,
      input  flush,
      output m_data,
      output m_keep,
      output m_valid,
      input  m_ready,
      output underrun_cnt
   );

   modport slave (
      input  fifo_rd_enb,
      output fifo_rd_data,
      output fifo_empty,
      output fifo_underrun,
      output flush,
      input  m_data,
      input  m_keep,
      input  m_valid,
      output m_ready,
      input  underrun_cnt
   );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Pops DATA_WIDTH-bit entries from a FIFO read port (two cycles per pop),
//   packs LANES of them little-endian into one word and presents it on a
//   valid/ready stream. A flush emits the partial word with a lane-keep mask.
//   Reads that come back flagged as underrun are discarded and counted.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fifo_word_packer_if.master (FIFO read port, flush, output
//            stream, saturating underrun counter)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | may issue a read, serve a pending flush
// CAPT    | read data/underrun from the FIFO valid; capture or discard
module fifo_word_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_word_packer_if.master   bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CAPT = 1'b1;

   localparam logic [CNT_WIDTH-1:0] LANES_C = CNT_WIDTH'(LANES);

   logic [0:0]                          state;
   logic [CNT_WIDTH-1:0]                cnt;
   logic [LANES-1:0][DATA_WIDTH-1:0]    acc;
   logic                                flush_pend;

   logic [DATA_WIDTH*LANES-1:0]         m_data_q;
   logic [LANES-1:0]                    m_keep_q;
   logic                                m_valid_q;
   logic [7:0]                          ucnt_q;

   logic                                out_free;
   logic                                load_full;
   logic                                serve_flush;
   logic                                rd_go;
   logic [LANES-1:0]                    keep_part;

   assign out_free    = !m_valid_q || bus.m_ready;
   assign load_full   = (cnt == LANES_C) && out_free;
   assign serve_flush = (state == ST_IDLE) && flush_pend && out_free && (cnt < LANES_C);

   // A flush arriving this cycle blocks the read so the partial word it
   // will emit is not extended by a byte still in flight.
   assign rd_go = (state == ST_IDLE) && !bus.fifo_empty && (cnt < LANES_C)
                  && !flush_pend && !bus.flush;

   assign keep_part = LANES'((32'd1 << cnt) - 32'd1);

   // Read request is combinational from IDLE so the byte lands in the very
   // next (CAPT) cycle; gated by reset so it reads 0 while held in reset.
   assign bus.fifo_rd_enb  = rd_go && rst_n;
   assign bus.m_data       = m_data_q;
   assign bus.m_keep       = m_keep_q;
   assign bus.m_valid      = m_valid_q;
   assign bus.underrun_cnt = ucnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         acc        <= '0;
         flush_pend <= 1'b0;
         m_data_q   <= '0;
         m_keep_q   <= '0;
         m_valid_q  <= 1'b0;
         ucnt_q     <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: if (rd_go) state <= ST_CAPT;
            default: state <= ST_IDLE;
         endcase

         if (state == ST_CAPT) begin
            if (!bus.fifo_underrun) begin
               acc[cnt[CNT_WIDTH-2:0]] <= bus.fifo_rd_data;
               cnt                     <= cnt + 1'b1;
            end else if (ucnt_q != 8'hFF) begin
               ucnt_q <= ucnt_q + 8'd1;
            end
         end

         if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;

         // Full word wins over flush service; the two are mutually exclusive
         // because flush service requires cnt < LANES.
         if (load_full) begin
            m_data_q  <= acc;
            m_keep_q  <= '1;
            m_valid_q <= 1'b1;
            cnt       <= '0;
            acc       <= '0;
         end else if (serve_flush) begin
            if (cnt != '0) begin
               m_data_q  <= acc;
               m_keep_q  <= keep_part;
               m_valid_q <= 1'b1;
               cnt       <= '0;
               acc       <= '0;
            end
         end

         // A new pulse in the same cycle as service re-arms the request.
         if (serve_flush) flush_pend <= 1'b0;
         if (bus.flush)   flush_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;
   localparam int DW = 8;
   localparam int L  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_word_packer_if #(.DATA_WIDTH(DW), .LANES(L)) bus ();

   fifo_word_packer #(.DATA_WIDTH(DW), .LANES(L), .CNT_WIDTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0]  fifo_q[$];
   logic [7:0]  part_q[$];
   logic [31:0] exp_data[$];
   logic [3:0]  exp_keep[$];
   logic [31:0] got_data[$];
   logic [3:0]  got_keep[$];

   int rd_pulses    = 0;
   int uflow_issued = 0;
   int force_until  = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: bytes actually delivered by the FIFO (no underrun)
   // are grouped LANES at a time into little-endian words; a flush closes
   // whatever partial group exists.
   function automatic void model_byte(logic [7:0] b);
      logic [31:0] w;
      part_q.push_back(b);
      if (part_q.size() == L) begin
         w = '0;
         for (int i = 0; i < L; i++) w[8*i +: 8] = part_q[i];
         exp_data.push_back(w);
         exp_keep.push_back(4'hF);
         part_q.delete();
      end
   endfunction

   function automatic void model_flush();
      logic [31:0] w;
      int n;
      n = part_q.size();
      if (n > 0) begin
         w = '0;
         for (int i = 0; i < n; i++) w[8*i +: 8] = part_q[i];
         exp_data.push_back(w);
         exp_keep.push_back(4'((1 << n) - 1));
         part_q.delete();
      end
   endfunction

   // Byte FIFO model: registered read data, underrun and empty flag.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.fifo_rd_data  <= '0;
         bus.fifo_underrun <= 1'b0;
         bus.fifo_empty    <= 1'b1;
      end else begin
         bus.fifo_underrun <= 1'b0;
         if (bus.fifo_rd_enb) begin
            if (uflow_issued < force_until) begin
               bus.fifo_underrun <= 1'b1;
               bus.fifo_rd_data  <= 8'hEE;
               uflow_issued      <= uflow_issued + 1;
            end else if (fifo_q.size() > 0) begin
               bus.fifo_rd_data <= fifo_q[0];
               model_byte(fifo_q[0]);
               fifo_q.delete(0);
            end else begin
               bus.fifo_underrun <= 1'b1;
            end
         end
         bus.fifo_empty <= (fifo_q.size() == 0);
      end
   end

   // Compare process: sampled on the falling edge.
   logic        prev_rd    = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] hold_d     = '0;
   logic [3:0]  hold_k     = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_rd    <= 1'b0;
         prev_stall <= 1'b0;
      end else begin
         if (bus.fifo_rd_enb) begin
            rd_pulses <= rd_pulses + 1;
            check("rd_back_to_back", 32'(prev_rd), 32'd0);
         end
         if (prev_stall) begin
            check("stall_valid", 32'(bus.m_valid), 32'd1);
            check("stall_data", bus.m_data, hold_d);
            check("stall_keep", 32'(bus.m_keep), 32'(hold_k));
         end
         if (bus.m_valid && bus.m_ready) begin
            got_data.push_back(bus.m_data);
            got_keep.push_back(bus.m_keep);
            if (exp_data.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got 0x%0h expected none", bus.m_data);
            end else begin
               check("word_data", bus.m_data, exp_data.pop_front());
               check("word_keep", 32'(bus.m_keep), 32'(exp_keep.pop_front()));
            end
         end
         prev_rd    <= bus.fifo_rd_enb;
         prev_stall <= bus.m_valid && !bus.m_ready;
         hold_d     <= bus.m_data;
         hold_k     <= bus.m_keep;
      end
   end

   task automatic settle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_words(int n, int budget, string name);
      int k = 0;
      while (got_data.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(got_data.size() >= n), 32'd1);
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int vseen;
      int k;
      bus.flush   = 1'b0;
      bus.m_ready = 1'b1;

      // Reset values
      #2;
      check("rst_rd_enb", 32'(bus.fifo_rd_enb), 32'd0);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_m_data", bus.m_data, 32'd0);
      check("rst_m_keep", 32'(bus.m_keep), 32'd0);
      check("rst_ucnt", 32'(bus.underrun_cnt), 32'd0);

      // Preloaded full word
      fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
      fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
      base = rd_pulses;
      @(negedge clk);
      rst_n = 1'b1;
      wait_words(1, 60, "t1_word_timeout");
      settle(6);
      check("t1_pulses", 32'(rd_pulses - base), 32'd4);
      check("t1_data", got_data[0], 32'h44332211);
      check("t1_keep", 32'(got_keep[0]), 32'hF);

      // Partial word via flush, then a flush on an empty accumulator
      fifo_q.push_back(8'hA1); fifo_q.push_back(8'hA2);
      settle(12);
      model_flush();
      pulse_flush();
      wait_words(2, 20, "t2_word_timeout");
      check("t2_data", got_data[1], 32'h0000A2A1);
      check("t2_keep", 32'(got_keep[1]), 32'h3);
      settle(2);
      model_flush();
      pulse_flush();
      vseen = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.m_valid) vseen++;
         @(negedge clk);
      end
      check("t2_empty_flush_silent", 32'(vseen), 32'd0);

      // Backpressure: 12 bytes with m_ready low for 20 cycles
      bus.m_ready = 1'b0;
      base = rd_pulses;
      for (int i = 1; i <= 12; i++) fifo_q.push_back(8'(i));
      settle(20);
      check("t3_pulses_stalled", 32'(rd_pulses - base), 32'd8);
      check("t3_hold_valid", 32'(bus.m_valid), 32'd1);
      check("t3_hold_data", bus.m_data, 32'h04030201);
      bus.m_ready = 1'b1;
      wait_words(5, 100, "t3_word_timeout");
      check("t3_w0", got_data[2], 32'h04030201);
      check("t3_w1", got_data[3], 32'h08070605);
      check("t3_w2", got_data[4], 32'h0C0B0A09);
      settle(6);

      // Underrun: one dropped read, then 300 to saturate
      force_until = uflow_issued + 1;
      fifo_q.push_back(8'h55);
      settle(12);
      check("t4_ucnt_one", 32'(bus.underrun_cnt), 32'd1);
      force_until = uflow_issued + 300;
      fifo_q.push_back(8'h66);
      k = 0;
      while (uflow_issued < force_until && k < 800) begin
         @(negedge clk);
         k++;
      end
      check("t4_uflow_timeout", 32'(uflow_issued >= force_until), 32'd1);
      settle(8);
      check("t4_ucnt_sat", 32'(bus.underrun_cnt), 32'd255);
      model_flush();
      pulse_flush();
      wait_words(6, 20, "t4_word_timeout");
      check("t4_data", got_data[5], 32'h00006655);
      check("t4_keep", 32'(got_keep[5]), 32'h3);
      settle(4);

      // Reset with 3 bytes accumulated and a word pending
      bus.m_ready = 1'b0;
      for (int i = 0; i < 7; i++) fifo_q.push_back(8'h10 + 8'(i));
      settle(24);
      check("t5_pre_valid", 32'(bus.m_valid), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(bus.m_valid), 32'd0);
      check("t5_rst_data", bus.m_data, 32'd0);
      check("t5_rst_keep", 32'(bus.m_keep), 32'd0);
      check("t5_rst_ucnt", 32'(bus.underrun_cnt), 32'd0);
      check("t5_rst_rd_enb", 32'(bus.fifo_rd_enb), 32'd0);
      fifo_q.delete();
      part_q.delete();
      exp_data.delete();
      exp_keep.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      bus.m_ready = 1'b1;
      fifo_q.push_back(8'h21); fifo_q.push_back(8'h22);
      fifo_q.push_back(8'h23); fifo_q.push_back(8'h24);
      wait_words(7, 60, "t5_word_timeout");
      check("t5_data", got_data[6], 32'h24232221);
      check("t5_keep", 32'(got_keep[6]), 32'hF);

      settle(10);
      check("no_leftover_expected", 32'(exp_data.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
